// File: rtl/tdisto_ctrl_if.sv
// Bundle between the mode-decision side, the distortion sequencer and the
// Hadamard-weighted-sum engine. The sequencer takes the slave modport.
interface tdisto_ctrl_if #(
  parameter int unsigned ACC_WIDTH = 32
);
  logic                 start;
  logic                 mode;
  logic [2047:0]        src;
  logic [2047:0]        pred;
  logic [255:0]         w;
  logic                 tt_start;
  logic [127:0]         tt_in;
  logic [255:0]         tt_w;
  logic signed [31:0]   tt_sum;
  logic                 tt_done;
  logic [ACC_WIDTH-1:0] disto;
  logic                 done;
  logic                 busy;

  modport master (
    output start, mode, src, pred, w, tt_sum, tt_done,
    input  tt_start, tt_in, tt_w, disto, done, busy
  );

  modport slave (
    input  start, mode, src, pred, w, tt_sum, tt_done,
    output tt_start, tt_in, tt_w, disto, done, busy
  );
endinterface

// File: rtl/tdisto_ctrl.sv
// Spectral distortion sequencer: feeds src/pred 4x4 blocks alternately into a
// shared transform engine, pairs the returned sums and accumulates
// |sum_src - sum_pred| >> SHIFT over one block or a full 16x16 macroblock.
module tdisto_ctrl #(
  parameter int unsigned SHIFT     = 5,
  parameter int unsigned ACC_WIDTH = 32
) (
  input logic          clk,
  input logic          rst_n,
  tdisto_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StFin} state_e;

  state_e               state_q;
  logic                 mode_q;
  logic [5:0]           issue_cnt_q;
  logic [5:0]           res_cnt_q;
  logic [31:0]          sum_a_q;
  logic [ACC_WIDTH-1:0] acc_q;
  logic [ACC_WIDTH-1:0] disto_q;
  logic                 tt_start_q;
  logic [127:0]         tt_in_q;
  logic                 done_q;
  logic                 busy_q;

  logic [4:0]           slot;
  logic [2047:0]        frame;
  logic [127:0]         blk;
  logic [5:0]           n_ops;
  logic [32:0]          diff;
  logic [32:0]          mag;
  logic [32:0]          mag_sh;
  logic [ACC_WIDTH-1:0] acc_next;
  logic                 last_res;
  logic                 collect;

  // Block extraction for the next issue slot; even slots take src, odd take pred.
  // Slot bits [4:1] are block k, so {k/4, r, k%4, c} is directly the byte index.
  always_comb begin
    slot  = (state_q == StIdle) ? 5'd0 : issue_cnt_q[4:0];
    frame = slot[0] ? bus.pred : bus.src;
    blk   = '0;
    for (int i = 0; i < 16; i++) begin
      blk[{i[3:0], 3'b000} +: 8] =
        frame[{slot[4:3], i[3:2], slot[2:1], i[1:0], 3'b000} +: 8];
    end
  end

  // Pairing arithmetic: 33-bit signed difference, magnitude, scaled contribution.
  always_comb begin
    n_ops    = mode_q ? 6'd32 : 6'd2;
    diff     = {bus.tt_sum[31], bus.tt_sum} - {sum_a_q[31], sum_a_q};
    mag      = diff[32] ? (33'd0 - diff) : diff;
    mag_sh   = mag >> SHIFT;
    acc_next = acc_q + ACC_WIDTH'(mag_sh);
    collect  = bus.tt_done && (state_q == StIssue || state_q == StDrain);
    last_res = collect && (res_cnt_q == n_ops - 6'd1);
  end

  // Sequencer FSM with registered engine strobe, block data and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      mode_q      <= 1'b0;
      issue_cnt_q <= '0;
      res_cnt_q   <= '0;
      sum_a_q     <= '0;
      acc_q       <= '0;
      disto_q     <= '0;
      tt_start_q  <= 1'b0;
      tt_in_q     <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // Results may arrive while later slots are still being issued.
      if (collect) begin
        res_cnt_q <= res_cnt_q + 6'd1;
        if (!res_cnt_q[0]) begin
          sum_a_q <= bus.tt_sum;
        end else begin
          acc_q <= acc_next;
        end
      end

      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (bus.start) begin
            mode_q      <= bus.mode;
            issue_cnt_q <= 6'd1;
            res_cnt_q   <= '0;
            sum_a_q     <= '0;
            acc_q       <= '0;
            tt_start_q  <= 1'b1;
            tt_in_q     <= blk;
            busy_q      <= 1'b1;
            state_q     <= StIssue;
          end
        end
        StIssue: begin
          if (issue_cnt_q < n_ops) begin
            tt_start_q  <= 1'b1;
            tt_in_q     <= blk;
            issue_cnt_q <= issue_cnt_q + 6'd1;
          end else begin
            tt_start_q <= 1'b0;
            tt_in_q    <= '0;
            state_q    <= StDrain;
          end
        end
        StDrain: begin
          if (last_res) begin
            disto_q <= acc_next;
            done_q  <= 1'b1;
            state_q <= StFin;
          end
        end
        StFin: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.tt_start = tt_start_q;
  assign bus.tt_in    = tt_in_q;
  assign bus.tt_w     = bus.w;
  assign bus.disto    = disto_q;
  assign bus.done     = done_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_tdisto_ctrl.sv
// Directed bench for tdisto_ctrl with a behavioural 2-cycle TTransform engine.
module tb_tdisto_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  tdisto_ctrl_if bus ();

  tdisto_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Engine model: Walsh-Hadamard of the 4x4 block, sum of w[i] * |coeff[i]|.
  function automatic logic signed [31:0] ttrans(input logic [127:0] b, input logic [255:0] wv);
    int tmp[16];
    int a0, a1, a2, a3, s;
    int c[4];
    s = 0;
    for (int i = 0; i < 4; i++) begin
      a0 = int'(b[8*(4*i+0) +: 8]) + int'(b[8*(4*i+2) +: 8]);
      a1 = int'(b[8*(4*i+1) +: 8]) + int'(b[8*(4*i+3) +: 8]);
      a2 = int'(b[8*(4*i+1) +: 8]) - int'(b[8*(4*i+3) +: 8]);
      a3 = int'(b[8*(4*i+0) +: 8]) - int'(b[8*(4*i+2) +: 8]);
      tmp[4*i+0] = a0 + a1;
      tmp[4*i+1] = a3 + a2;
      tmp[4*i+2] = a3 - a2;
      tmp[4*i+3] = a0 - a1;
    end
    for (int i = 0; i < 4; i++) begin
      a0 = tmp[i] + tmp[8+i];
      a1 = tmp[4+i] + tmp[12+i];
      a2 = tmp[4+i] - tmp[12+i];
      a3 = tmp[i] - tmp[8+i];
      c[0] = a0 + a1;
      c[1] = a3 + a2;
      c[2] = a3 - a2;
      c[3] = a0 - a1;
      for (int j = 0; j < 4; j++) begin
        s += int'($signed(wv[16*(4*j+i) +: 16])) * ((c[j] < 0) ? -c[j] : c[j]);
      end
    end
    return s;
  endfunction

  logic               eng_v1   = 1'b0;
  logic signed [31:0] eng_s1   = '0;
  logic               eng_done = 1'b0;
  logic signed [31:0] eng_sum  = '0;
  logic               spur_done;
  logic signed [31:0] spur_sum;

  always @(posedge clk) begin
    eng_v1   <= bus.tt_start;
    eng_s1   <= ttrans(bus.tt_in, bus.tt_w);
    eng_done <= eng_v1;
    eng_sum  <= eng_s1;
  end

  assign bus.tt_done = eng_done | spur_done;
  assign bus.tt_sum  = spur_done ? spur_sum : eng_sum;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [127:0] tin11, tin12;

  // One operation from accept; checks timing, done count and optionally disto.
  task automatic op(input string tag, input logic m, input int inject,
                    input logic chk_disto, input logic [31:0] exp_disto);
    int   n2, done_cyc, done_cnt, ts_hi, ts_first, ts_last;
    logic busy1, busy_after;
    logic [31:0] disto_done;
    n2 = m ? 32 : 2;
    done_cyc = 0; done_cnt = 0; ts_hi = 0; ts_first = 0; ts_last = 0;
    busy1 = 1'b0; busy_after = 1'b1; disto_done = '0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = m;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int cyc = 1; cyc <= n2 + 8; cyc++) begin
      if (cyc == 1) busy1 = bus.busy;
      if (bus.tt_start) begin
        ts_hi++;
        if (ts_first == 0) ts_first = cyc;
        ts_last = cyc;
      end
      if (cyc == 11) tin11 = bus.tt_in;
      if (cyc == 12) tin12 = bus.tt_in;
      if (bus.done) begin
        done_cnt++;
        if (done_cyc == 0) begin
          done_cyc   = cyc;
          disto_done = bus.disto;
        end
      end
      if (done_cyc != 0 && cyc == done_cyc + 1) busy_after = bus.busy;
      if (cyc == inject) bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
    end
    chk({tag, "_busy_rise"}, 256'(busy1), 256'(1'b1));
    chk({tag, "_ts_first"}, 256'(ts_first), 256'(1));
    chk({tag, "_ts_last"}, 256'(ts_last), 256'(n2));
    chk({tag, "_ts_count"}, 256'(ts_hi), 256'(n2));
    chk({tag, "_done_cycle"}, 256'(done_cyc), 256'(n2 + 3));
    chk({tag, "_done_count"}, 256'(done_cnt), 256'(1));
    chk({tag, "_busy_fall"}, 256'(busy_after), 256'(1'b0));
    if (chk_disto) begin
      chk({tag, "_disto_at_done"}, 256'(disto_done), 256'(exp_disto));
      chk({tag, "_disto_held"}, 256'(bus.disto), 256'(exp_disto));
    end
  endtask

  initial begin
    logic no_done;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.mode = 1'b0;
    bus.src = '0; bus.pred = '0; bus.w = '0;
    spur_done = 1'b0; spur_sum = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 256'(bus.busy), 256'(1'b0));
    chk("rst_done", 256'(bus.done), 256'(1'b0));
    chk("rst_tt_start", 256'(bus.tt_start), 256'(1'b0));
    chk("rst_tt_in", 256'(bus.tt_in), 256'(0));
    chk("rst_disto", 256'(bus.disto), 256'(0));
    @(negedge clk) rst_n = 1'b1;

    // Identical src/pred -> zero distortion.
    bus.src = {256{8'h40}}; bus.pred = {256{8'h40}}; bus.w = {16{16'h0001}};
    op("flat", 1'b0, 0, 1'b1, 32'd0);

    // Single pixel 32: sums 512 vs 0 -> 512 >> 5 = 16.
    bus.src = '0; bus.src[7:0] = 8'd32; bus.pred = '0;
    op("impulse", 1'b0, 0, 1'b1, 32'd16);
    chk("tt_w_pass", bus.tt_w, bus.w);

    // Negative weights: -512 vs 0 -> |d| = 512 -> 16.
    bus.w = {16{16'hFFFF}};
    op("neg_w", 1'b0, 0, 1'b1, 32'd16);

    // Macroblock: DC 4080 per block -> 127 each, 16 * 127 = 2032.
    bus.src = '0; bus.pred = {256{8'hFF}}; bus.w = '0; bus.w[15:0] = 16'd1;
    op("mb", 1'b1, 0, 1'b1, 32'd2032);
    chk("tt_w_mb", bus.tt_w, bus.w);

    // start while busy is ignored.
    op("mb_restart", 1'b1, 10, 1'b1, 32'd2032);

    // Byte mapping for block 5 (rows 4..7, cols 4..7): src byte n = n, pred = ~n.
    for (int n = 0; n < 256; n++) begin
      bus.src[8*n +: 8]  = n[7:0];
      bus.pred[8*n +: 8] = ~n[7:0];
    end
    op("map", 1'b1, 0, 1'b0, 32'd0);
    chk("map_src_k5", 256'(tin11), 256'(128'h77767574_67666564_57565554_47464544));
    chk("map_pred_k5", 256'(tin12), 256'(128'h88898A8B_98999A9B_A8A9AAAB_B8B9BABB));

    // Reset in cycle 12 of a macroblock run.
    bus.src = '0; bus.pred = {256{8'hFF}};
    @(negedge clk);
    bus.start = 1'b1; bus.mode = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int cyc = 1; cyc < 12; cyc++) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 256'(bus.busy), 256'(1'b0));
    chk("abort_done", 256'(bus.done), 256'(1'b0));
    chk("abort_tt_start", 256'(bus.tt_start), 256'(1'b0));
    chk("abort_tt_in", 256'(bus.tt_in), 256'(0));
    chk("abort_disto", 256'(bus.disto), 256'(0));
    no_done = 1'b1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(posedge clk);
      #1 if (bus.done) no_done = 1'b0;
    end
    chk("abort_no_done", 256'(no_done), 256'(1'b1));
    @(negedge clk) rst_n = 1'b1;

    bus.src = '0; bus.src[7:0] = 8'd32; bus.pred = '0; bus.w = {16{16'h0001}};
    op("post_rst", 1'b0, 0, 1'b1, 32'd16);

    // Spurious tt_done in IDLE must not disturb pairing.
    @(negedge clk);
    spur_sum  = 32'sd9999;
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    op("spurious", 1'b0, 0, 1'b1, 32'd16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdisto_ctrl.md
# tdisto_ctrl

Sequencer for the spectral distortion metric. It time-multiplexes one external Hadamard-weighted-sum engine (`TTransform`, 2-cycle latency) between source and prediction 4x4 blocks. It pairs the returned sums and accumulates `|sum_src - sum_pred| >> SHIFT` over one 4x4 block or sixteen 4x4 blocks of a 16x16 macroblock. It sits between the mode-decision logic and the transform engine, and the decision logic reads `disto` as the distortion term.

## Interface
- `SHIFT`, default 5: right shift applied to each per-block absolute difference.
- `ACC_WIDTH`, default 32: width of the `disto` accumulator.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; accepted only in IDLE.
- `mode`  in  1  0 = single 4x4 (block 0), 1 = full 16x16 (16 blocks); sampled at accept.
- `src`  in  2048  256 source bytes; byte n = `src[8n+7:8n]`, n = row*16+col; held stable while `busy`.
- `pred`  in  2048  prediction bytes, same layout and stability rule as `src`.
- `w`  in  256  sixteen signed 16-bit weights, passed through unchanged.
- `tt_start`  out  1  engine issue strobe.
- `tt_in`  out  128  4x4 block to engine; byte i = pixel (i/4, i%4).
- `tt_w`  out  256  equals `w`.
- `tt_sum`  in  32  signed engine result.
- `tt_done`  in  1  engine result valid.
- `disto`  out  ACC_WIDTH  accumulated distortion; held until the next accept.
- `done`  out  1  one-cycle completion pulse.
- `busy`  out  1  high from the cycle after accept through the `done` cycle.

## Operation
- Reset values: `tt_start`=0, `tt_in`=0, `done`=0, `busy`=0, `disto`=0. Reset also clears all counters and the pairing register, and puts the FSM in IDLE.
- FSM states and transitions:
  - IDLE -> ISSUE on `start`. On accept: latch `mode`, N = mode ? 16 : 1, clear accumulator and counters.
  - ISSUE: issue 2N engine operations, one per cycle, then -> DRAIN.
  - DRAIN: wait until 2N results are collected, then -> FIN.
  - FIN: pulse `done`, copy the accumulator to `disto`, then -> IDLE.
- Issue order is k = 0..N-1. For each k, issue the src block on the even slot and the pred block on the following odd slot.
- Block k covers rows 4(k/4)..+3 and cols 4(k%4)..+3. Pixel (r,c) of block k is byte (4(k/4)+r)*16 + 4(k%4) + c.
- `tt_in` and `tt_start` are registered, so slot j is driven in cycle j+1 after the accept edge.
- Result collection: a result counter advances on each `tt_done`.
  - Even result: store `tt_sum` as A.
  - Odd result (B): compute d = B - A at 33-bit signed width. Take |d| at 33 bits, shift right logically by SHIFT, truncate to ACC_WIDTH, and add to the accumulator modulo 2^ACC_WIDTH.
- `tt_done` in IDLE or FIN is ignored. `start` while busy is ignored; it is neither queued nor able to corrupt state.
- Reset mid-operation aborts immediately. No `done` is produced, `disto` reads 0, and the next `start` after release behaves as from power-up.

## Timing
- Cycle 0 is the edge where `start` is sampled in IDLE. `busy` rises in cycle 1.
- `tt_start` is high for cycles 1..2N continuously, with no bubbles.
- The engine returns `tt_done` in cycles 3..2N+2, in issue order.
- The final accumulate happens at the end of cycle 2N+2. `done`=1 and the new `disto` are valid in cycle 2N+3, and `busy` falls after that cycle.
- Latency from accept to `done`: 5 cycles for mode 0, 35 cycles for mode 1.
- A new `start` is accepted from the cycle after `done`, so back-to-back throughput is one op per 2N+4 cycles.

## Test plan
- Mode 0, src = pred = all 0x40, w = all 1 -> `tt_start` high in cycles 1–2, `done` in cycle 5, `disto`=0.
- Mode 0, src all 0 except byte 0 = 32, pred all 0, w all 1 -> `tt_sum` values 512 then 0, `disto`=16. Repeat with w all 0xFFFF -> `disto`=16.
- Mode 1, src all 0, pred all 0xFF, w[0]=1 and other weights 0 -> each block gives 4080 vs 0 and contributes 127, `disto`=2032, `done` in cycle 35. Check `tt_in` byte mapping for k=5.
- Mode 1 run with a `start` pulse in cycle 10 -> ignored, single `done` at cycle 35, `disto` unchanged from the previous case.
- Reset asserted in cycle 12 of a mode-1 run -> all outputs 0 asynchronously, no `done`. A subsequent mode-0 run completes correctly at cycle 5.
- Spurious `tt_done` in IDLE followed by a mode-0 run -> `disto` matches the clean run.
